// File: rtl/yuv422_fb_reader.sv
// yuv422_fb_reader
//
// Scan-out stage behind the YUV422 framebuffer BRAM. It issues one read address per active
// pixel and absorbs the BRAM read latency. It rebuilds full 4:4:4 pixels from Cb/Cr pairs and
// delays de/hsync/vsync so they leave in step with the pixel data.
//
// Ports:
//   clk_i      pixel clock
//   rst_ni     asynchronous active-low reset
//   de_i       active-video enable from the timing generator
//   hsync_i    horizontal sync (active-high)
//   vsync_i    vertical sync (active-high); a rising edge restarts the address at 0
//   rd_addr_o  framebuffer pixel read address (registered)
//   rd_d_i     framebuffer pixel: [15:8]=Y, [7:0]=Cb (even pixel) or Cr (odd pixel)
//   de_o       enable delayed by RD_LAT+2
//   hsync_o    hsync delayed by RD_LAT+2
//   vsync_o    vsync delayed by RD_LAT+2
//   y_o        luma
//   cb_o       blue-difference chroma
//   cr_o       red-difference chroma
module yuv422_fb_reader #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned RD_LAT = 1,
  // Derived; leave at its default.
  parameter int unsigned AW     = $clog2(LINES * 2)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          de_i,
  input  logic          hsync_i,
  input  logic          vsync_i,
  output logic [AW-1:0] rd_addr_o,
  input  logic [15:0]   rd_d_i,
  output logic          de_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic [7:0]    y_o,
  output logic [7:0]    cb_o,
  output logic [7:0]    cr_o
);

  localparam int unsigned L = RD_LAT + 2;

  localparam logic [7:0] YBlack = 8'h10;
  localparam logic [7:0] CNeutral = 8'h80;

  // Address generation and parity
  logic [AW-1:0] addr_q, addr_d;
  logic          vsync_q;
  logic          de_prev_q;
  logic          x0_q, x0_d;
  logic          frame_start;
  logic          par_cur;

  // Delay lines; bit j holds the value presented j+1 cycles ago.
  logic [L-1:0]    de_dly_q, hs_dly_q, vs_dly_q;
  logic [RD_LAT:0] par_dly_q;

  // Capture stage and output stage
  logic [15:0] s1_d_q;
  logic [7:0]  cb_hold_q, cb_hold_d;
  logic [7:0]  y_q, y_d, cb_q, cb_d, cr_q, cr_d;

  // Pixel currently on rd_d_i, and the one sitting in the capture stage
  logic in_de, in_par, s1_de, s1_par;

  assign frame_start = vsync_i & ~vsync_q;

  always_comb begin
    // Parity restarts at 0 on the first active cycle of each line.
    par_cur = (de_i & ~de_prev_q) ? 1'b0 : x0_q;
    x0_d    = de_i ? ~par_cur : x0_q;
    addr_d  = addr_q;
    if (frame_start) begin
      addr_d = '0;
    end else if (de_i) begin
      addr_d = addr_q + AW'(1);
    end
  end

  assign in_de  = de_dly_q[RD_LAT-1];
  assign in_par = par_dly_q[RD_LAT-1];
  assign s1_de  = de_dly_q[RD_LAT];
  assign s1_par = par_dly_q[RD_LAT];

  // An even pixel leaving the capture stage pairs with the pixel arriving on rd_d_i in the
  // same cycle; an odd pixel reuses the Cb remembered from its even partner.
  always_comb begin
    y_d       = YBlack;
    cb_d      = CNeutral;
    cr_d      = CNeutral;
    cb_hold_d = cb_hold_q;
    if (s1_de) begin
      y_d = s1_d_q[15:8];
      if (!s1_par) begin
        cb_d      = s1_d_q[7:0];
        cb_hold_d = s1_d_q[7:0];
        cr_d      = (in_de && in_par) ? rd_d_i[7:0] : CNeutral;
      end else begin
        cb_d = cb_hold_q;
        cr_d = s1_d_q[7:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      vsync_q   <= 1'b0;
      de_prev_q <= 1'b0;
      x0_q      <= 1'b0;
      de_dly_q  <= '0;
      hs_dly_q  <= '0;
      vs_dly_q  <= '0;
      par_dly_q <= '0;
      s1_d_q    <= '0;
      cb_hold_q <= CNeutral;
      y_q       <= YBlack;
      cb_q      <= CNeutral;
      cr_q      <= CNeutral;
    end else begin
      addr_q    <= addr_d;
      vsync_q   <= vsync_i;
      de_prev_q <= de_i;
      x0_q      <= x0_d;
      de_dly_q  <= {de_dly_q[L-2:0], de_i};
      hs_dly_q  <= {hs_dly_q[L-2:0], hsync_i};
      vs_dly_q  <= {vs_dly_q[L-2:0], vsync_i};
      par_dly_q <= {par_dly_q[RD_LAT-1:0], par_cur};
      s1_d_q    <= rd_d_i;
      cb_hold_q <= cb_hold_d;
      y_q       <= y_d;
      cb_q      <= cb_d;
      cr_q      <= cr_d;
    end
  end

  assign rd_addr_o = addr_q;
  assign de_o      = de_dly_q[L-1];
  assign hsync_o   = hs_dly_q[L-1];
  assign vsync_o   = vs_dly_q[L-1];
  assign y_o       = y_q;
  assign cb_o      = cb_q;
  assign cr_o      = cr_q;

endmodule

// File: tb/tb_yuv422_fb_reader.sv
// Bench for yuv422_fb_reader: two instances (RD_LAT=1 and RD_LAT=3) share the same timing
// inputs, each fed by its own BRAM model. A per-cycle record of presented pixels is kept and
// expected outputs are derived from it L cycles later.
module tb_yuv422_fb_reader;

  localparam int NPIX = 32;
  localparam int NREC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, de, hs, vs;
  logic [4:0]  addr1, addr3;
  logic [15:0] d1, d3;
  logic        de1, hs1, vs1, de3, hs3, vs3;
  logic [7:0]  y1, cb1, cr1, y3, cb3, cr3;

  yuv422_fb_reader #(.LINES(16), .RD_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .de_i(de), .hsync_i(hs), .vsync_i(vs),
    .rd_addr_o(addr1), .rd_d_i(d1), .de_o(de1), .hsync_o(hs1), .vsync_o(vs1),
    .y_o(y1), .cb_o(cb1), .cr_o(cr1)
  );

  yuv422_fb_reader #(.LINES(16), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .de_i(de), .hsync_i(hs), .vsync_i(vs),
    .rd_addr_o(addr3), .rd_d_i(d3), .de_o(de3), .hsync_o(hs3), .vsync_o(vs3),
    .y_o(y3), .cb_o(cb3), .cr_o(cr3)
  );

  // Framebuffer models with 1 and 3 cycles of read latency
  logic [15:0] mem [NPIX];
  logic [15:0] p1;
  logic [15:0] p3 [3];
  always @(posedge clk) begin
    p1    <= mem[addr1];
    p3[0] <= mem[addr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign d1 = p1;
  assign d3 = p3[2];

  int n_chk = 0;
  int n_fail = 0;

  // Record of what was presented in each cycle
  logic        rec_de   [NREC];
  logic        rec_hs   [NREC];
  logic        rec_vs   [NREC];
  logic        rec_par  [NREC];
  logic [15:0] rec_data [NREC];
  int cycle = 0;

  // Reference state: pixels since frame start, position within current active run
  int   m_addr = 0;
  int   m_run = 0;
  logic m_de_prev = 1'b0;
  logic m_vs_prev = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
    end
  endtask

  task automatic expect_pix(input int k, output logic ed, output logic eh, output logic ev,
                            output logic [7:0] ey, output logic [7:0] ecb,
                            output logic [7:0] ecr);
    ed = 1'b0; eh = 1'b0; ev = 1'b0;
    ey = 8'h10; ecb = 8'h80; ecr = 8'h80;
    if (k >= 0) begin
      ed = rec_de[k];
      eh = rec_hs[k];
      ev = rec_vs[k];
      if (ed) begin
        ey = rec_data[k][15:8];
        if (!rec_par[k]) begin
          ecb = rec_data[k][7:0];
          if (rec_de[k+1] && rec_par[k+1]) ecr = rec_data[k+1][7:0];
        end else begin
          ecb = rec_data[k-1][7:0];
          ecr = rec_data[k][7:0];
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic ed, eh, ev;
    logic [7:0] ey, ecb, ecr;
    chk("rd_addr1", {11'd0, addr1}, 16'(m_addr));
    chk("rd_addr3", {11'd0, addr3}, 16'(m_addr));
    expect_pix(cycle - 3, ed, eh, ev, ey, ecb, ecr);
    chk("de1", {15'd0, de1}, {15'd0, ed});
    chk("hs1", {15'd0, hs1}, {15'd0, eh});
    chk("vs1", {15'd0, vs1}, {15'd0, ev});
    chk("y1", {8'd0, y1}, {8'd0, ey});
    chk("cb1", {8'd0, cb1}, {8'd0, ecb});
    chk("cr1", {8'd0, cr1}, {8'd0, ecr});
    expect_pix(cycle - 5, ed, eh, ev, ey, ecb, ecr);
    chk("de3", {15'd0, de3}, {15'd0, ed});
    chk("hs3", {15'd0, hs3}, {15'd0, eh});
    chk("vs3", {15'd0, vs3}, {15'd0, ev});
    chk("y3", {8'd0, y3}, {8'd0, ey});
    chk("cb3", {8'd0, cb3}, {8'd0, ecb});
    chk("cr3", {8'd0, cr3}, {8'd0, ecr});
  endtask

  // One clock cycle: check this cycle's outputs, then drive inputs r(eset), d(e), h, v.
  task automatic step(input logic r, input logic d, input logic h, input logic v);
    @(negedge clk);
    check_outputs();
    rst_n = ~r;
    de = d;
    hs = h;
    vs = v;
    if (r) begin
      // Everything still in flight is discarded.
      for (int k = cycle - 4; k <= cycle; k++) begin
        if (k >= 0) begin
          rec_de[k] = 1'b0; rec_hs[k] = 1'b0; rec_vs[k] = 1'b0;
          rec_par[k] = 1'b0; rec_data[k] = 16'h0;
        end
      end
      m_addr = 0; m_run = 0; m_de_prev = 1'b0; m_vs_prev = 1'b0;
    end else begin
      if (d) m_run = m_de_prev ? m_run + 1 : 0;
      rec_de[cycle]   = d;
      rec_hs[cycle]   = h;
      rec_vs[cycle]   = v;
      rec_par[cycle]  = d & (m_run % 2 == 1);
      rec_data[cycle] = mem[m_addr];
      if (v && !m_vs_prev) m_addr = 0;
      else if (d) m_addr = (m_addr + 1) % NPIX;
      m_vs_prev = v;
      m_de_prev = d;
    end
    cycle++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    idle(2);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
  endtask

  task automatic line(input int n);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NREC; i++) begin
      rec_de[i] = 1'b0; rec_hs[i] = 1'b0; rec_vs[i] = 1'b0;
      rec_par[i] = 1'b0; rec_data[i] = 16'h0;
    end
    for (int i = 0; i < NPIX; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h5011;
    mem[1] = 16'h60EE;
    mem[2] = 16'h7022;
    mem[3] = 16'h80DD;
    rst_n = 1'b0; de = 1'b0; hs = 1'b0; vs = 1'b0;

    // Reset held with de toggling
    for (int i = 0; i < 5; i++) step(1'b1, i[0], 1'b0, 1'b0);
    idle(3);

    // 4-pixel line from address 0
    vsync_pulse();
    line(4);
    idle(4);

    // 3-pixel line, then a 4-pixel line continuing at address 3
    vsync_pulse();
    line(3);
    line(4);

    // 40 active pixels: address wraps 31 -> 0 and ends at 7
    vsync_pulse();
    repeat (5) line(8);

    // Frame restart after 10 pixels
    vsync_pulse();
    line(10);
    vsync_pulse();
    line(4);

    // vsync rising together with de
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    line(5);

    // Reset mid-line, then resume with de high
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    line(6);

    // vsync held high through reset release counts as a frame start
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b1);
    idle(3);
    line(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rd, rh, rv;
      rd = ($urandom_range(0, 3) != 0);
      rh = ($urandom_range(0, 15) == 0);
      rv = ($urandom_range(0, 60) == 0);
      step(1'b0, rd, rh, rv);
    end
    idle(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
